div_tap_select: RTL

- Downstream consumer of the binary ripple-tap divider counter.
- Takes the counter's 11 power-of-two taps (f/2 to f/2048) and selects one at runtime.
- Produces a registered divided-clock level (div_out) and a one-cycle rising-edge strobe (tick) for clock-enable use.
- Tap switching is glitch-free: there are never runt high or low phases shorter than one clk cycle, and the old high phase is never truncated.

---
 rtl/div_tap_select.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_tap_select.sv
// div_tap_select
//   Selects one power-of-two tap of the ripple divider counter at runtime and
//   produces a registered divided-clock level plus a rising-edge strobe.
//   Tap changes are glitch-free: the old tap's high phase always completes,
//   at least one low cycle separates old and new high phases, and the new tap
//   is only picked up from its low phase.
//
// Ports
//   clk        system clock (same clock as the tap counter)
//   reset      synchronous, active-high reset
//   taps       counter taps; tap k toggles every 2^k cycles
//   sel        requested tap index
//   sel_valid  select request present
//   sel_ready  request can be accepted (RUN only)
//   sel_err    one-cycle pulse: accepted request was out of range
//   busy       tap switch in progress
//   cur_sel    tap index currently driving div_out
//   div_out    registered selected tap level
//   tick       one-cycle pulse on each rising edge of div_out in RUN
module div_tap_select #(
    parameter int NTAPS       = 11,
    parameter int SEL_W       = 4,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NTAPS-1:0] taps,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic             sel_err,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel,
    output logic             div_out,
    output logic             tick
);

    localparam int unsigned NTAPS_U = NTAPS;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ARM
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] pend;
    logic [SEL_W-1:0] pend_n;
    logic [SEL_W-1:0] cur_sel_n;
    logic             div_n;
    logic             tick_n;
    logic             err_n;
    logic             tap_cur;
    logic             accept;
    logic             sel_oob;

    // Tap mux written as a compare loop so cur_sel never indexes past NTAPS.
    always_comb begin
        tap_cur = 1'b0;
        for (int unsigned k = 0; k < NTAPS_U; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                tap_cur = taps[k];
            end
        end
    end

    assign sel_ready = (state == RUN);
    assign busy      = ~sel_ready;
    assign accept    = sel_valid && sel_ready;
    assign sel_oob   = (32'(sel) >= NTAPS_U);

    always_comb begin
        state_n   = state;
        pend_n    = pend;
        cur_sel_n = cur_sel;
        div_n     = 1'b0;
        tick_n    = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            RUN: begin
                div_n  = tap_cur;
                tick_n = tap_cur && !div_out;
                if (accept) begin
                    if (sel_oob) begin
                        err_n = 1'b1;
                    end else if (sel != cur_sel) begin
                        pend_n  = sel;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Old tap keeps driving the output until its high phase ends.
                div_n = tap_cur;
                if (!tap_cur) begin
                    cur_sel_n = pend;
                    state_n   = ARM;
                end
            end
            ARM: begin
                // Hold low until the new tap is in its low phase.
                if (!tap_cur) begin
                    state_n = RUN;
                end
            end
            default: state_n = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARM;
            pend    <= '0;
            cur_sel <= SEL_W'(DEFAULT_SEL);
            div_out <= 1'b0;
            tick    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            cur_sel <= cur_sel_n;
            div_out <= div_n;
            tick    <= tick_n;
            sel_err <= err_n;
        end
    end

endmodule
